// File: rtl/wait_state_ctrl.sv
// Bus responder for cpu_6502: wait-state insertion, region steering
// and a held read-data mux for cpu_di.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   ab, cpu_do,
//   cpu_we          - CPU access request (held while rdy=0)
//   cpu_di, rdy     - read data and ready back to the CPU
//   mem_*           - synchronous backing memory (single-cycle strobes)
//   io_*            - external I/O port with ready handshake
//   bus_err         - sticky flag, set when an I/O access times out
module wait_state_ctrl #(
  parameter logic [15:0] SLOW_BASE    = 16'hC000,
  parameter logic [15:0] SLOW_MASK    = 16'hC000,
  parameter int unsigned SLOW_WAITS   = 2,
  parameter logic [15:0] IO_BASE      = 16'hBF00,
  parameter logic [15:0] IO_MASK      = 16'hFF00,
  parameter int unsigned IO_MIN_WAITS = 1,
  parameter int unsigned IO_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_sel,
  output logic        io_re,
  output logic        io_we,
  input  logic        io_ready,
  input  logic [7:0]  io_rdata,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;

  localparam logic [7:0] SW_M1   = 8'(SLOW_WAITS - 1);
  localparam logic [7:0] IO_MIN  = 8'(IO_MIN_WAITS);
  localparam logic [7:0] IO_TO   = 8'(IO_TIMEOUT);
  localparam logic       SLOW_EN = (SLOW_WAITS != 0);
  localparam logic       IO_ZERO = (IO_MIN_WAITS == 0);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       src_mem_q, src_mem_d;
  logic       err_q, err_d;

  logic io_hit, slow_hit;
  logic rdy_c, io_sel_c;
  logic mem_done, io_hs, io_to;

  assign io_hit   = (ab & IO_MASK) == IO_BASE;
  assign slow_hit = SLOW_EN && ((ab & SLOW_MASK) == SLOW_BASE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_c    = 1'b1;
    io_sel_c = 1'b0;
    mem_done = 1'b0;
    io_hs    = 1'b0;
    io_to    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io_hit) begin
          io_sel_c = 1'b1;
          if (IO_ZERO && io_ready) begin
            io_hs = 1'b1;
          end else begin
            rdy_c   = 1'b0;
            cnt_d   = 8'd1;
            state_d = S_IO;
          end
        end else if (slow_hit) begin
          rdy_c   = 1'b0;
          cnt_d   = SW_M1;
          state_d = S_SLOW;
        end else begin
          mem_done = 1'b1;
        end
      end
      S_SLOW: begin
        if (cnt_q == 8'd0) begin
          mem_done = 1'b1;
          state_d  = S_IDLE;
        end else begin
          rdy_c = 1'b0;
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_IO: begin
        io_sel_c = 1'b1;
        // a late handshake wins over the timeout in the same cycle
        if ((cnt_q >= IO_MIN) && io_ready) begin
          io_hs   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (cnt_q == IO_TO) begin
          io_to   = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          rdy_c = 1'b0;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // read completions pick the cpu_di source; writes leave it alone
  always_comb begin
    data_d    = data_q;
    src_mem_d = src_mem_q;
    err_d     = err_q;
    if (mem_done && !cpu_we) begin
      src_mem_d = 1'b1;
    end
    if (io_hs && !cpu_we) begin
      data_d    = io_rdata;
      src_mem_d = 1'b0;
    end
    if (io_to) begin
      err_d = 1'b1;
      if (!cpu_we) begin
        data_d    = 8'hFF;
        src_mem_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      data_q    <= 8'h00;
      src_mem_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      src_mem_q <= src_mem_d;
      err_q     <= err_d;
    end
  end

  // memory holds mem_rdata between mem_re pulses, so it can be
  // muxed straight through after a memory read completes
  assign cpu_di    = src_mem_q ? mem_rdata : data_q;
  assign rdy       = reset | rdy_c;
  assign mem_addr  = ab;
  assign mem_wdata = cpu_do;
  assign mem_re    = !reset && mem_done && !cpu_we;
  assign mem_we    = !reset && mem_done && cpu_we;
  assign io_addr   = ab[7:0];
  assign io_wdata  = cpu_do;
  assign io_sel    = !reset && io_sel_c;
  assign io_re     = !reset && io_hs && !cpu_we;
  assign io_we     = !reset && io_hs && cpu_we;
  assign bus_err   = err_q;

endmodule

// File: doc/wait_state_ctrl.md
# wait_state_ctrl

Synthesizable bus responder for the `cpu_6502` core. It decodes each CPU access by address region and drives `rdy` low for a fixed or handshake-determined number of wait states. It steers the access to a synchronous backing memory or an external I/O port. It holds `cpu_di` stable across stalls, so the CPU never sees undefined data while `rdy` is low. It sits between `cpu_6502` and the memory/peripheral fabric at the system top.

## Interface
Parameters:
- `SLOW_BASE`, 16'hC000, slow-memory region base (match: `(ab & SLOW_MASK) == SLOW_BASE`)
- `SLOW_MASK`, 16'hC000, slow-memory region mask
- `SLOW_WAITS`, 2, wait states for slow region (0..255; 0 = behaves as fast)
- `IO_BASE`, 16'hBF00, I/O region base
- `IO_MASK`, 16'hFF00, I/O region mask
- `IO_MIN_WAITS`, 1, minimum wait states for I/O before `io_ready` is honoured (0..254)
- `IO_TIMEOUT`, 64, cycles after access start at which an I/O access is force-completed (`IO_MIN_WAITS` < `IO_TIMEOUT` ≤ 255)

Ports:
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `ab` in 16 — CPU address
- `cpu_do` in 8 — CPU write data
- `cpu_we` in 1 — CPU write enable
- `cpu_di` out 8 — read data to CPU
- `rdy` out 1 — to CPU `RDY`; 1 = current access completes at this edge
- `mem_addr` out 16 — equals `ab`
- `mem_wdata` out 8 — equals `cpu_do`
- `mem_re` / `mem_we` out 1 — single-cycle memory read/write strobes
- `mem_rdata` in 8 — memory read data; registered by memory, updates only on `mem_re`
- `io_addr` out 8 — `ab[7:0]`
- `io_wdata` out 8 — equals `cpu_do`
- `io_sel` out 1 — high in every cycle of an I/O access
- `io_re` / `io_we` out 1 — single-cycle I/O strobes at handshake completion
- `io_ready` in 1 — peripheral ready
- `io_rdata` in 8 — I/O read data, valid with `io_ready`
- `bus_err` out 1 — sticky I/O timeout flag

## Operation
- Region priority: I/O > slow > fast (everything else; memory-backed, 0 waits).
- An access starts in the first cycle `ab`/`cpu_we` are presented in IDLE. The CPU holds `ab`, `cpu_we` and `cpu_do` while `rdy`=0. The region is latched at start.
- FSM states: IDLE, SLOW_WAIT, IO_WAIT. An 8-bit counter `cnt` serves both wait states.
- IDLE:
  - fast → `rdy`=1.
  - slow with `SLOW_WAITS`>0 → `rdy`=0, `cnt`←`SLOW_WAITS`-1, go SLOW_WAIT.
  - I/O → `rdy`=(`IO_MIN_WAITS`==0 && `io_ready`); if not done, `cnt`←1 and go IO_WAIT.
- SLOW_WAIT: `rdy`=(`cnt`==0); otherwise decrement `cnt`. Return to IDLE on `rdy`.
- IO_WAIT (`cnt` = cycles elapsed since start):
  - done if (`cnt`≥`IO_MIN_WAITS` && `io_ready`) or `cnt`==`IO_TIMEOUT`.
  - `rdy`=done; else increment `cnt`.
  - IDLE on done.
- Strobes are asserted only in the completing cycle (`rdy`=1):
  - `mem_re`/`mem_we` for fast/slow regions per `cpu_we`.
  - `io_re`/`io_we` for I/O only on a handshake completion, never on timeout; a timed-out write is dropped.
- `cpu_di` is a hold mux. Each read completion selects the source: memory → `mem_rdata`; I/O → `io_rdata` registered at completion; timeout → 8'hFF. Write completions leave `cpu_di` unchanged.
- `bus_err` is set at a timeout completion and cleared only by `reset`.

## Timing
- Access started in cycle t:
  - fast completes at t.
  - slow completes at t+`SLOW_WAITS`.
  - I/O completes at the first t+k with k≥`IO_MIN_WAITS` and `io_ready`, else at t+`IO_TIMEOUT`.
- Read data on `cpu_di` from cycle t_complete+1 until the next read completion.
- Back-to-back accesses: the cycle after completion is a new access start, counted in full. Same-address repeats count too.
- Reset values, held while `reset`=1:
  - `rdy`=1; `cpu_di`=8'h00.
  - all strobes 0; `io_sel`=0; `bus_err`=0.
  - state IDLE, `cnt`=0.
- Reset mid-wait: the wait is abandoned with no strobe, and the first cycle after `reset` falls is a new IDLE start.
- Exactly one strobe per access; never a strobe while `rdy`=0.

## Test plan
- Fast read `ab`=16'h0400, `mem_rdata`=8'h3C → `rdy`=1 in the same cycle, one `mem_re` pulse, `cpu_di`=8'h3C next cycle.
- Slow read `ab`=16'hC000, `SLOW_WAITS`=2 → `rdy` 0,0,1; `mem_re` only in the 3rd cycle; `cpu_di` holds its previous value during the stall.
- Back-to-back slow writes to 16'hC010 (8'hA5) then 16'hC011 (8'h5A) → 3 cycles each, exactly two `mem_we` pulses with matching `mem_addr`/`mem_wdata`.
- I/O read 16'hBF02, `io_ready` rises at t+4 with `io_rdata`=8'h5A → `rdy`=1 at t+4, one `io_re`, `cpu_di`=8'h5A from t+5 and held through later stalls.
- I/O write with `io_ready` held 0 → `rdy`=1 at t+64, no `io_we`, `bus_err`=1 and it stays 1 until `reset`. Repeat as a read → `cpu_di`=8'hFF.
- Assert `reset` during SLOW_WAIT → `rdy`=1, no strobes, `bus_err`=0. The next slow access after release again takes `SLOW_WAITS`+1 cycles.
